// File: rtl/ppu_mem_pkg.sv
// Shared types and constants for the PPU memory arbiter: address map,
// PPU mode encoding, OAM DMA states and CPU read-return tags.
package ppu_mem_pkg;

  localparam int unsigned DMA_LEN = 160;
  localparam logic [7:0]  OPEN_BUS = 8'hFF;

  localparam logic [15:0] VRAM_BASE = 16'h8000;
  localparam logic [15:0] VRAM_END  = 16'h9FFF;
  localparam logic [15:0] OAM_BASE  = 16'hFE00;
  localparam logic [15:0] OAM_END   = 16'hFE9F;
  localparam logic [15:0] DMA_REG   = 16'hFF46;

  typedef enum logic [1:0] {
    MODE_HBLANK   = 2'd0,
    MODE_VBLANK   = 2'd1,
    MODE_OAM_SCAN = 2'd2,
    MODE_DRAW     = 2'd3
  } ppu_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    READ  = 2'd2,
    WRITE = 2'd3
  } dma_state_t;

  typedef enum logic [1:0] {
    TAG_VRAM = 2'd0,
    TAG_OAM  = 2'd1,
    TAG_REG  = 2'd2,
    TAG_OPEN = 2'd3
  } rd_tag_t;

  // Echo RAM pages 0xE0-0xFF alias work RAM 0xC0-0xDF, so DMA never reads OAM/IO.
  function automatic logic [7:0] fold_src(input logic [7:0] hi);
    return (hi >= 8'hE0) ? (hi - 8'h20) : hi;
  endfunction

endpackage

// File: rtl/oam_dma_engine.sv
// OAM DMA engine: holds the 0xFF46 page register and copies DMA_LEN bytes
// from {page,index} into OAM, one source read then one OAM write per byte.
// Ports: start/start_page (CPU write to 0xFF46), rd_req/src_addr/rd_ack/rdata
// (source bus), oam_we/oam_addr/oam_wdata (OAM write port), page_reg, active.
module oam_dma_engine
  import ppu_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  start_page,
  input  logic        rd_ack,
  input  logic [7:0]  rdata,
  output logic [7:0]  page_reg,
  output logic        active,
  output logic        rd_req,
  output logic [15:0] src_addr,
  output logic        oam_we,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata
);

  localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

  dma_state_t state;
  logic [7:0] src_hi;
  logic [7:0] index;

  // Transfer FSM; a new 0xFF46 write restarts from index 0 in any state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      page_reg  <= 8'h00;
      src_hi    <= 8'h00;
      index     <= 8'h00;
      rd_req    <= 1'b0;
      src_addr  <= 16'h0000;
      oam_we    <= 1'b0;
      oam_addr  <= 8'h00;
      oam_wdata <= 8'h00;
    end else if (start) begin
      state    <= START;
      page_reg <= start_page;
      src_hi   <= fold_src(start_page);
      index    <= 8'h00;
      rd_req   <= 1'b0;
      oam_we   <= 1'b0;
    end else begin
      case (state)
        START: begin
          state    <= READ;
          rd_req   <= 1'b1;
          src_addr <= {src_hi, index};
        end
        READ: begin
          if (rd_ack) begin
            state     <= WRITE;
            rd_req    <= 1'b0;
            oam_we    <= 1'b1;
            oam_addr  <= index;
            oam_wdata <= rdata;
          end
        end
        WRITE: begin
          oam_we <= 1'b0;
          if (index == LAST_IDX) begin
            state <= IDLE;
          end else begin
            state    <= READ;
            index    <= index + 8'd1;
            rd_req   <= 1'b1;
            src_addr <= {src_hi, index + 8'd1};
          end
        end
        default: ;
      endcase
    end
  end

  assign active = (state != IDLE);

endmodule

// File: rtl/ppu_mem_arbiter.sv
// Arbitrates VRAM and OAM between the CPU bus, the PPU fetcher and OAM DMA,
// applying the DMG mode locks. CPU gets ack one cycle after any hit on
// VRAM/OAM/0xFF46; blocked reads return OPEN_BUS, blocked writes are dropped.
// Ports: cpu_* (CPU bus), lcd_on/ppu_mode (lock inputs), ppu_* (PPU reads),
// vram_*/oam_* (block RAMs, 1-cycle sync read), dma_* (DMA source bus).
// Optional feature macro: PPU_OAM_DMA_EN enables the DMA engine and 0xFF46;
// without it 0xFF46 reads OPEN_BUS, writes are ignored, dma outputs tie to 0.
module ppu_mem_arbiter
  import ppu_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  input  logic        lcd_on,
  input  logic [1:0]  ppu_mode,
  input  logic [12:0] ppu_vram_addr,
  output logic [7:0]  ppu_vram_rdata,
  input  logic [7:0]  ppu_oam_addr,
  output logic [7:0]  ppu_oam_rdata,
  output logic [12:0] vram_addr,
  output logic [7:0]  vram_wdata,
  output logic        vram_we,
  input  logic [7:0]  vram_rdata,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata,
  output logic        oam_we,
  input  logic [7:0]  oam_rdata,
  output logic        dma_rd_req,
  output logic [15:0] dma_src_addr,
  input  logic        dma_rd_ack,
  input  logic [7:0]  dma_rdata,
  output logic        dma_active
);

  ppu_mode_t mode;
  logic      vram_hit, oam_hit, reg_hit;
  logic      vram_lock, oam_lock;
  logic      vram_grant, oam_grant, reg_wr;
  rd_tag_t   tag_d, tag_q;
  logic      vram_steal_q, oam_steal_q;
  logic [7:0] dma_reg, dma_oam_addr, dma_oam_wdata;
  logic       dma_oam_we;

  assign mode     = ppu_mode_t'(ppu_mode);
  assign vram_hit = (cpu_addr >= VRAM_BASE) && (cpu_addr <= VRAM_END);
  assign oam_hit  = (cpu_addr >= OAM_BASE) && (cpu_addr <= OAM_END);
  assign reg_hit  = (cpu_addr == DMA_REG);

  assign vram_lock = lcd_on && (mode == MODE_DRAW);
  assign oam_lock  = (lcd_on && ((mode == MODE_OAM_SCAN) || (mode == MODE_DRAW)))
                     || dma_active;

  assign vram_grant = cpu_req && vram_hit && !vram_lock;
  assign oam_grant  = cpu_req && oam_hit && !oam_lock;
  assign reg_wr     = cpu_req && cpu_we && reg_hit;

`ifdef PPU_OAM_DMA_EN
  localparam bit DMA_EN = 1'b1;

  oam_dma_engine u_dma (
    .clk        (clk),
    .rst        (rst),
    .start      (reg_wr),
    .start_page (cpu_wdata),
    .rd_ack     (dma_rd_ack),
    .rdata      (dma_rdata),
    .page_reg   (dma_reg),
    .active     (dma_active),
    .rd_req     (dma_rd_req),
    .src_addr   (dma_src_addr),
    .oam_we     (dma_oam_we),
    .oam_addr   (dma_oam_addr),
    .oam_wdata  (dma_oam_wdata)
  );
`else
  localparam bit DMA_EN = 1'b0;

  logic unused_dma_in;
  assign unused_dma_in = dma_rd_ack ^ (^dma_rdata);

  assign dma_reg       = 8'h00;
  assign dma_active    = 1'b0;
  assign dma_rd_req    = 1'b0;
  assign dma_src_addr  = 16'h0000;
  assign dma_oam_we    = 1'b0;
  assign dma_oam_addr  = 8'h00;
  assign dma_oam_wdata = 8'h00;
`endif

  // VRAM port: CPU when granted this cycle, PPU otherwise.
  assign vram_addr  = vram_grant ? cpu_addr[12:0] : ppu_vram_addr;
  assign vram_wdata = cpu_wdata;
  assign vram_we    = vram_grant && cpu_we;

  // OAM port: DMA, then CPU, then PPU. A same-cycle 0xFF46 write kills the pending DMA byte.
  always_comb begin
    oam_addr  = ppu_oam_addr;
    oam_wdata = cpu_wdata;
    oam_we    = 1'b0;
    if (dma_active) begin
      oam_addr  = dma_oam_addr;
      oam_wdata = dma_oam_wdata;
      oam_we    = dma_oam_we && !reg_wr;
    end else if (oam_grant) begin
      oam_addr = cpu_addr[7:0];
      oam_we   = cpu_we;
    end
  end

  // Source of the CPU read data returned with next cycle's ack.
  always_comb begin
    tag_d = TAG_OPEN;
    if (vram_grant && !cpu_we)             tag_d = TAG_VRAM;
    else if (oam_grant && !cpu_we)         tag_d = TAG_OAM;
    else if (DMA_EN && reg_hit && !cpu_we) tag_d = TAG_REG;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_ack      <= 1'b0;
      tag_q        <= TAG_OPEN;
      vram_steal_q <= 1'b0;
      oam_steal_q  <= 1'b0;
    end else begin
      cpu_ack      <= cpu_req && (vram_hit || oam_hit || reg_hit);
      tag_q        <= tag_d;
      vram_steal_q <= vram_grant;
      oam_steal_q  <= oam_grant;
    end
  end

  // RAM outputs are already registered; the tag picks them in the ack cycle.
  always_comb begin
    cpu_rdata = 8'h00;
    if (cpu_ack) begin
      case (tag_q)
        TAG_VRAM: cpu_rdata = vram_rdata;
        TAG_OAM:  cpu_rdata = oam_rdata;
        TAG_REG:  cpu_rdata = dma_reg;
        default:  cpu_rdata = OPEN_BUS;
      endcase
    end
  end

  // RAM data following a CPU- or DMA-owned cycle is not the PPU's.
  assign ppu_vram_rdata = vram_steal_q ? OPEN_BUS : vram_rdata;
  assign ppu_oam_rdata  = (oam_steal_q || dma_active) ? OPEN_BUS : oam_rdata;

endmodule

// File: tb/tb_ppu_mem_arbiter.sv
// Directed bench for ppu_mem_arbiter with behavioural VRAM/OAM RAMs and a
// DMA source responder that acks every request in the cycle it is seen.
module tb_ppu_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        cpu_ack, lcd_on;
  logic [1:0]  ppu_mode;
  logic [12:0] ppu_vram_addr, vram_addr;
  logic [7:0]  ppu_vram_rdata, ppu_oam_addr, ppu_oam_rdata;
  logic [7:0]  vram_wdata, vram_rdata, oam_addr, oam_wdata, oam_rdata;
  logic        vram_we, oam_we;
  logic        dma_rd_req, dma_rd_ack, dma_active;
  logic [15:0] dma_src_addr;
  logic [7:0]  dma_rdata;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int c0;
  int errs;

  logic [7:0]  vram_mem [0:8191];
  logic [7:0]  oam_mem  [0:255];
  logic [15:0] rd_log[$];
  logic [15:0] wr_log[$];

  logic        s_ack, s_vram_we, s_oam_we;
  logic [7:0]  s_rdata, s_oam_addr, s_oam_wdata;
  logic [12:0] s_vram_addr;

  ppu_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .lcd_on(lcd_on), .ppu_mode(ppu_mode),
    .ppu_vram_addr(ppu_vram_addr), .ppu_vram_rdata(ppu_vram_rdata),
    .ppu_oam_addr(ppu_oam_addr), .ppu_oam_rdata(ppu_oam_rdata),
    .vram_addr(vram_addr), .vram_wdata(vram_wdata), .vram_we(vram_we), .vram_rdata(vram_rdata),
    .oam_addr(oam_addr), .oam_wdata(oam_wdata), .oam_we(oam_we), .oam_rdata(oam_rdata),
    .dma_rd_req(dma_rd_req), .dma_src_addr(dma_src_addr), .dma_rd_ack(dma_rd_ack),
    .dma_rdata(dma_rdata), .dma_active(dma_active)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] src_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // Sync-read RAMs plus logs of DMA handshakes and OAM writes.
  always @(posedge clk) begin
    if (vram_we) vram_mem[vram_addr] <= vram_wdata;
    vram_rdata <= vram_mem[vram_addr];
    if (oam_we) begin
      oam_mem[oam_addr] <= oam_wdata;
      wr_log.push_back({oam_addr, oam_wdata});
    end
    oam_rdata <= oam_mem[oam_addr];
    if (dma_rd_req && dma_rd_ack) rd_log.push_back(dma_src_addr);
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    dma_rd_ack = dma_rd_req;
    dma_rdata  = src_byte(dma_src_addr);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One CPU access, started on a negedge; returns on the next negedge (ack cycle).
  task automatic cpu_op(input logic we, input logic [15:0] addr, input logic [7:0] wd);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wd;
    #1;
    s_vram_we   = vram_we;
    s_vram_addr = vram_addr;
    s_oam_we    = oam_we;
    s_oam_addr  = oam_addr;
    s_oam_wdata = oam_wdata;
    @(negedge clk);
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
    s_ack   = cpu_ack;
    s_rdata = cpu_rdata;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (dma_active && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(dma_active), 32'd0);
  endtask

  task automatic wait_writes(input string tag, input int cnt);
    int n = 0;
    while (wr_log.size() < cnt && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(wr_log.size()), 32'(cnt));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
    lcd_on = 1'b0; ppu_mode = 2'd0; ppu_vram_addr = 13'h0000; ppu_oam_addr = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_ack",    32'(cpu_ack),    32'd0);
    check("rst_rdata",  32'(cpu_rdata),  32'd0);
    check("rst_active", 32'(dma_active), 32'd0);
    check("rst_rdreq",  32'(dma_rd_req), 32'd0);
    check("rst_oam_we", 32'(oam_we),     32'd0);
    check("rst_vram_we", 32'(vram_we),   32'd0);
    rst = 1'b1;
    @(negedge clk);

    // VRAM lock by mode 3
    cpu_op(1'b1, 16'h8000, 8'h3C);
    cpu_op(1'b1, 16'h8100, 8'h11);
    ppu_vram_addr = 13'h0100;
    lcd_on = 1'b1; ppu_mode = 2'd3;
    cpu_op(1'b0, 16'h8000, 8'h00);
    check("t1_lock_ack",   32'(s_ack),   32'd1);
    check("t1_lock_rdata", 32'(s_rdata), 32'hFF);
    check("t1_ppu_rdata",  32'(ppu_vram_rdata), 32'h11);
    @(negedge clk);
    check("t1_ack_pulse",  32'(cpu_ack), 32'd0);
    ppu_mode = 2'd0;
    cpu_op(1'b0, 16'h8000, 8'h00);
    check("t1_open_rdata", 32'(s_rdata), 32'h3C);
    check("t1_ppu_open",   32'(ppu_vram_rdata), 32'hFF);

    // OAM lock by mode 2
    ppu_mode = 2'd2;
    cpu_op(1'b1, 16'hFE10, 8'h5A);
    check("t2_lock_we",  32'(s_oam_we), 32'd0);
    check("t2_lock_ack", 32'(s_ack),    32'd1);
    ppu_mode = 2'd1;
    cpu_op(1'b1, 16'hFE10, 8'h5A);
    check("t2_we",    32'(s_oam_we),    32'd1);
    check("t2_addr",  32'(s_oam_addr),  32'h10);
    check("t2_wdata", 32'(s_oam_wdata), 32'h5A);
    ppu_mode = 2'd2;
    cpu_op(1'b0, 16'hFE10, 8'h00);
    check("t2_lock_rd", 32'(s_rdata), 32'hFF);
    ppu_mode = 2'd0;
    cpu_op(1'b0, 16'hFE10, 8'h00);
    check("t2_rd", 32'(s_rdata), 32'h5A);

    // LCD off: no lock even in mode 3
    lcd_on = 1'b0; ppu_mode = 2'd3;
    cpu_op(1'b1, 16'h9FFF, 8'h77);
    check("t3_we",   32'(s_vram_we),   32'd1);
    check("t3_addr", 32'(s_vram_addr), 32'h1FFF);
    cpu_op(1'b0, 16'h9FFF, 8'h00);
    check("t3_rd", 32'(s_rdata), 32'h77);
    cpu_op(1'b0, 16'hFEA0, 8'h00);
    check("bnd_fea0_ack", 32'(s_ack), 32'd0);
    cpu_op(1'b0, 16'h7FFF, 8'h00);
    check("bnd_7fff_ack", 32'(s_ack), 32'd0);
    ppu_mode = 2'd0;

`ifdef PPU_OAM_DMA_EN
    // Full transfer from 0xC100
    rd_log.delete(); wr_log.delete();
    cpu_op(1'b1, 16'hFF46, 8'hC1);
    c0 = cyc;
    check("t4_wr_ack", 32'(s_ack), 32'd1);
    repeat (10) @(negedge clk);
    check("t4_active",   32'(dma_active),    32'd1);
    check("t4_ppu_oam",  32'(ppu_oam_rdata), 32'hFF);
    cpu_op(1'b0, 16'hFE00, 8'h00);
    check("t4_cpu_oam",  32'(s_rdata), 32'hFF);
    cpu_op(1'b0, 16'hFF46, 8'h00);
    check("t4_reg_rd",   32'(s_rdata), 32'hC1);
    wait_idle("t4_idle");
    check("t4_cycles",   32'(cyc - c0), 32'd321);
    check("t4_rd_cnt",   32'(rd_log.size()), 32'd160);
    check("t4_wr_cnt",   32'(wr_log.size()), 32'd160);
    errs = 0;
    for (int i = 0; i < 160 && i < rd_log.size() && i < wr_log.size(); i++) begin
      if (rd_log[i] != 16'hC100 + 16'(i)) errs++;
      if (wr_log[i] != {8'(i), src_byte(16'hC100 + 16'(i))}) errs++;
    end
    check("t4_seq_errs", 32'(errs), 32'd0);
    cpu_op(1'b0, 16'hFE9F, 8'h00);
    check("t4_oam_last", 32'(s_rdata), 32'h04);

    // Folded source and mid-transfer restart
    rd_log.delete(); wr_log.delete();
    cpu_op(1'b1, 16'hFF46, 8'hE2);
    wait_writes("t5_wait80", 80);
    check("t5_first_src", 32'(rd_log[0]), 32'hC200);
    cpu_op(1'b1, 16'hFF46, 8'hD0);
    rd_log.delete(); wr_log.delete();
    wait_idle("t5_idle");
    check("t5_restart_src", 32'(rd_log[0]), 32'hD000);
    check("t5_restart_wr",  32'(wr_log[0]), 32'h008A);
    check("t5_wr_cnt",      32'(wr_log.size()), 32'd160);

    // Reset in the middle of the write of index 40
    wr_log.delete();
    cpu_op(1'b1, 16'hFF46, 8'hC3);
    begin
      int n = 0;
      while (!(oam_we && oam_addr == 8'd40) && n < 1000) begin
        @(negedge clk);
        n++;
      end
      check("t6_reach40", 32'(oam_we && oam_addr == 8'd40), 32'd1);
    end
    rst = 1'b0;
    #1;
    check("t6_active", 32'(dma_active), 32'd0);
    check("t6_oam_we", 32'(oam_we),     32'd0);
    check("t6_rdreq",  32'(dma_rd_req), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check("t6_wr_cnt",    32'(wr_log.size()), 32'd40);
    check("t6_idle",      32'(dma_active),    32'd0);
    cpu_op(1'b0, 16'hFF46, 8'h00);
    check("t6_reg_reset", 32'(s_rdata), 32'h00);
`else
    // Without the DMA engine 0xFF46 is acked but inert
    cpu_op(1'b1, 16'hFF46, 8'hC1);
    check("nd_wr_ack", 32'(s_ack), 32'd1);
    repeat (3) @(negedge clk);
    check("nd_active", 32'(dma_active), 32'd0);
    check("nd_rdreq",  32'(dma_rd_req), 32'd0);
    cpu_op(1'b0, 16'hFF46, 8'h00);
    check("nd_rd_ack", 32'(s_ack),   32'd1);
    check("nd_rd",     32'(s_rdata), 32'hFF);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
